uart_bus_responder: RTL and testbench
=====================================

// Module: uart_bus_responder
// PURPOSE
// - Device side of the parallel serial-port bus (data_ready/rdn/wrn/tbre/tsre) that the
//   controller drives as host. Converts host byte reads/writes to an 8N1 UART on rxd/txd.
// - Sits between the host controller's bus pins and the board's RS-232 transceiver.
// PARAMETERS
// - DIV       1152  CLK cycles per bit (11.0592 MHz / 9600 baud); must be >= 4
// - SYNC_LEN  2     flops in the rxd/rdn/wrn synchronisers
// PORTS
// - CLK         in   1  system clock; all logic on posedge
// - RST         in   1  reset, asynchronous, active-high
// - rdn         in   1  host read strobe, active-low
// - wrn         in   1  host write strobe, active-low
// - data_in     in   8  host-driven bus byte, sampled on wrn rise
// - data_out    out  8  byte presented to host while reading
// - data_oe     out  1  1 = responder drives bus (top level tristates with this)
// - data_ready  out  1  1 = at least one received byte waiting
// - tbre        out  1  1 = TX holding register empty
// - tsre        out  1  1 = TX shift register idle (line fully drained)
// - rxd         in   1  serial input, idle high
// - txd         out  1  serial output, idle high
// - frame_err   out  1  one-cycle pulse: stop bit sampled 0, byte discarded
// - overrun     out  1  one-cycle pulse: received byte lost, storage full
// - wr_drop     out  1  one-cycle pulse: host write while tbre=0, byte discarded
// BEHAVIOUR
// - Reset: txd=1, data_out=0, data_oe=0, data_ready=0, tbre=1, tsre=1, pulses 0, FSMs IDLE.
//   RST mid-frame aborts both directions at once; txd returns to 1 same edge.
// - rdn, wrn, rxd pass through SYNC_LEN flops; edges detected on synced copies.
// - Read: synced rdn fall -> data_oe=1, data_out=head byte (next edge). Held while rdn low.
//   synced rdn rise -> data_oe=0, head popped; data_ready updates same edge.
//   rdn low with data_ready=0: data_oe=1, data_out=8'h00, no pop.
// - Write: synced wrn rise -> if tbre=1 latch data_in into holding reg, tbre=0;
//   else wr_drop pulse, holding unchanged.
// - TX FSM: IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE; each state DIV cycles.
//   IDLE with holding full: move to shifter, tbre=1, tsre=0, enter START same edge.
//   At STOP end: back-to-back START if holding full, else IDLE and tsre=1.
// - RX FSM: IDLE -> START -> DATA -> STOP. Synced rxd fall starts; START re-checked at
//   DIV/2 (rxd=1 -> IDLE, glitch). Data/stop sampled every DIV from that midpoint.
//   Stop=0 -> frame_err, drop. Stop=1 -> push; storage full -> overrun, new byte dropped.
// - Pop and push on same edge: both take effect, data_ready stays 1, no overrun.
// - Bit counter 3 bits; baud counter $clog2(DIV) bits, wraps to 0 at DIV-1.
// CONFIGURATION
// - UART_BUS_RX_FIFO_EN defined: RX storage is a 4-deep FIFO (2-bit ptrs + 3-bit count);
//   overrun only when count=4. data_ready = (count != 0).
// - Undefined: single holding register + valid bit; overrun when valid=1 and no same-edge pop.
// STRUCTURE
// - Package uart_bus_pkg: TX/RX state enums (IDLE/START/DATA/STOP), RX_FIFO_DEPTH=4,
//   bit-count width localparams.
// - Sub-module uart_rx_deser: sync, start detect, mid-bit sampling; outputs byte+valid+
//   frame_err. TX path, bus handshake, RX storage stay in the top.
// TESTING
// - Reset: RST=1 mid-TX -> txd=1, tbre=1, tsre=1, data_ready=0, data_oe=0 immediately.
// - Host write 8'hA5 -> txd: 0,1,0,1,0,0,1,0,1,1 at DIV each; tbre=1 once shifted.
//   tsre=1 after stop.
// - Two writes 8'h55, 8'h0F back-to-back on tbre -> 20 bit times, no idle bit between.
//   A third write while tbre=0 -> wr_drop pulse; not transmitted.
// - rxd frame 8'h3C -> data_ready=1; rdn low -> data_oe=1, data_out=8'h3C;
//   rdn high -> data_oe=0, data_ready=0.
// - rxd frame with stop=0 -> frame_err 1 cycle, data_ready stays 0; 0.3*DIV low glitch
//   -> nothing.
// - Frames 8'h01..8'h05, no reads: FIFO_EN -> 4 held, overrun on 5th, reads 01..04;
//   no FIFO -> overrun on 2nd..5th, read returns 01.

Source files
------------

// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the UART bus responder and its RX deserialiser.
package uart_bus_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int RX_FIFO_DEPTH = 4;
    localparam int RX_PTR_W      = 2;
    localparam int RX_CNT_W      = 3;
    localparam int BIT_CNT_W     = 3;

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 receive deserialiser: synchronises rxd, detects the start edge, confirms the
// start bit at its midpoint and samples data/stop bits every DIV cycles from there.
// Emits a one-cycle valid pulse with the byte, or a one-cycle frame_err pulse.
module uart_rx_deser
    import uart_bus_pkg::*;
#(
    parameter int DIV      = 1152,
    parameter int SYNC_LEN = 2      // must be >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

    logic [SYNC_LEN-1:0]  sync_q, sync_d;
    logic                 prev_q, prev_d;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           byte_q, byte_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 rxd_s;
    logic                 baud_wrap;

    assign rxd_s       = sync_q[SYNC_LEN-1];
    assign byte_o      = byte_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

    // Next-state: synchroniser shift, start detect, mid-bit sampling.
    always_comb begin
        sync_d    = {sync_q[SYNC_LEN-2:0], rxd};
        prev_d    = rxd_s;
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        baud_wrap = (baud_q == BAUD_LAST);
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !rxd_s) begin
                    state_d = RX_START;
                    baud_d  = '0;
                end
            end
            RX_START: begin
                // Half a bit in: a line back at 1 was only a glitch.
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? RX_IDLE : RX_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_DATA: begin
                baud_d = baud_wrap ? '0 : baud_q + 1'b1;
                if (baud_wrap) begin
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_CNT_W'(7)) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                baud_d = baud_wrap ? '0 : baud_q + 1'b1;
                if (baud_wrap) begin
                    state_d = RX_IDLE;
                    if (rxd_s) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // State register; line idles high so synchronisers reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_LEN{1'b1}};
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: rtl/uart_bus_responder.sv
// Device side of the host parallel serial-port bus, bridging host byte reads/writes
// to an 8N1 UART. Optional macro UART_BUS_RX_FIFO_EN selects a 4-deep RX FIFO;
// without it RX storage is a single holding register.
module uart_bus_responder
    import uart_bus_pkg::*;
#(
    parameter int DIV      = 1152,  // clocks per bit, >= 4
    parameter int SYNC_LEN = 2      // >= 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rdn,
    input  logic       wrn,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    input  logic       rxd,
    output logic       txd,
    output logic       frame_err,
    output logic       overrun,
    output logic       wr_drop
);

    // Bus handshake: a host read is the low pulse of rdn; the byte is presented from the
    // synced fall until the synced rise, which consumes it. A host write is accepted on
    // the synced rise of wrn only when tbre=1 (holding empty); otherwise it is dropped.

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    logic [SYNC_LEN-1:0]  rdn_sync_q, rdn_sync_d, wrn_sync_q, wrn_sync_d;
    logic                 rdn_prev_q, rdn_prev_d, wrn_prev_q, wrn_prev_d;
    logic                 rd_fall, rd_rise, wr_rise;
    logic [7:0]           data_out_q, data_out_d;
    logic                 data_oe_q, data_oe_d, rd_had_q, rd_had_d;
    tx_state_t            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_baud_q, tx_baud_d;
    logic [BIT_CNT_W-1:0] tx_bit_q, tx_bit_d;
    logic [7:0]           tx_hold_q, tx_hold_d, tx_shift_q, tx_shift_d;
    logic                 tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d;
    logic                 wr_drop_q, wr_drop_d, overrun_q, overrun_d;
    logic                 tx_baud_last, tx_load;
    logic [7:0]           rx_byte, rx_head;
    logic                 rx_valid, rx_ready, rx_pop, rx_push;

    uart_rx_deser #(.DIV(DIV), .SYNC_LEN(SYNC_LEN)) u_rx (
        .clk        (CLK),
        .rst        (RST),
        .rxd        (rxd),
        .byte_o     (rx_byte),
        .valid_o    (rx_valid),
        .frame_err_o(frame_err)
    );

    assign rd_fall    = rdn_prev_q & ~rdn_sync_q[SYNC_LEN-1];
    assign rd_rise    = ~rdn_prev_q & rdn_sync_q[SYNC_LEN-1];
    assign wr_rise    = ~wrn_prev_q & wrn_sync_q[SYNC_LEN-1];
    // Only a read that showed a real byte consumes one.
    assign rx_pop     = rd_rise & rd_had_q;
    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign data_ready = rx_ready;
    assign tbre       = tbre_q;
    assign tsre       = tsre_q;
    assign txd        = txd_q;
    assign wr_drop    = wr_drop_q;
    assign overrun    = overrun_q;

    // Strobe synchronisers and the host read response.
    always_comb begin
        rdn_sync_d = {rdn_sync_q[SYNC_LEN-2:0], rdn};
        wrn_sync_d = {wrn_sync_q[SYNC_LEN-2:0], wrn};
        rdn_prev_d = rdn_sync_q[SYNC_LEN-1];
        wrn_prev_d = wrn_sync_q[SYNC_LEN-1];
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        rd_had_d   = rd_had_q;
        if (rd_fall) begin
            data_oe_d  = 1'b1;
            data_out_d = rx_ready ? rx_head : 8'h00;
            rd_had_d   = rx_ready;
        end else if (rd_rise) begin
            data_oe_d = 1'b0;
            rd_had_d  = 1'b0;
        end
    end

    // TX: host write into holding register, then START/DATA/STOP serialisation.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_baud_d    = tx_baud_q;
        tx_bit_d     = tx_bit_q;
        tx_hold_d    = tx_hold_q;
        tx_shift_d   = tx_shift_q;
        tbre_d       = tbre_q;
        tsre_d       = tsre_q;
        wr_drop_d    = 1'b0;
        tx_load      = 1'b0;
        tx_baud_last = (tx_baud_q == BAUD_LAST);
        if (wr_rise) begin
            if (tbre_q) begin
                tx_hold_d = data_in;
                tbre_d    = 1'b0;
            end else begin
                wr_drop_d = 1'b1;
            end
        end
        if (tx_state_q != TX_IDLE) tx_baud_d = tx_baud_last ? '0 : tx_baud_q + 1'b1;
        case (tx_state_q)
            TX_IDLE:  tx_load = ~tbre_q;
            TX_START: begin
                if (tx_baud_last) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_baud_last) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == BIT_CNT_W'(7)) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_baud_last) begin
                    if (!tbre_q) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tsre_d     = 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Holding -> shifter; frees the holding register for the next host write.
        if (tx_load) begin
            tx_shift_d = tx_hold_q;
            tbre_d     = 1'b1;
            tsre_d     = 1'b0;
            tx_state_d = TX_START;
            tx_baud_d  = '0;
        end
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

`ifdef UART_BUS_RX_FIFO_EN
    logic [7:0]          fifo_q [RX_FIFO_DEPTH];
    logic [7:0]          fifo_d [RX_FIFO_DEPTH];
    logic [RX_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RX_CNT_W-1:0] count_q, count_d;

    assign rx_ready = (count_q != '0);
    assign rx_head  = fifo_q[rd_ptr_q];

    // RX FIFO push/pop; a full FIFO still accepts when a pop frees a slot this edge.
    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rx_push   = rx_valid && ((count_q != RX_CNT_W'(RX_FIFO_DEPTH)) || rx_pop);
        overrun_d = rx_valid && !rx_push;
        if (rx_push) begin
            fifo_d[wr_ptr_q] = rx_byte;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (rx_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + RX_CNT_W'(rx_push) - RX_CNT_W'(rx_pop);
    end

    // RX FIFO storage registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;

    assign rx_ready = valid_q;
    assign rx_head  = hold_q;

    // Single holding register; a same-edge pop makes room for the new byte.
    always_comb begin
        hold_d    = hold_q;
        valid_d   = valid_q;
        rx_push   = rx_valid && (!valid_q || rx_pop);
        overrun_d = rx_valid && !rx_push;
        if (rx_pop) valid_d = 1'b0;
        if (rx_push) begin
            hold_d  = rx_byte;
            valid_d = 1'b1;
        end
    end

    // RX holding register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end
`endif

    // Bus-side and TX registers; reset aborts any frame and idles txd high at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdn_sync_q <= {SYNC_LEN{1'b1}};
            wrn_sync_q <= {SYNC_LEN{1'b1}};
            rdn_prev_q <= 1'b1;
            wrn_prev_q <= 1'b1;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            rd_had_q   <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_hold_q  <= '0;
            tx_shift_q <= '0;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            txd_q      <= 1'b1;
            wr_drop_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rdn_sync_q <= rdn_sync_d;
            wrn_sync_q <= wrn_sync_d;
            rdn_prev_q <= rdn_prev_d;
            wrn_prev_q <= wrn_prev_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            rd_had_q   <= rd_had_d;
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_hold_q  <= tx_hold_d;
            tx_shift_q <= tx_shift_d;
            tbre_q     <= tbre_d;
            tsre_q     <= tsre_d;
            txd_q      <= txd_d;
            wr_drop_q  <= wr_drop_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Bench for uart_bus_responder. Honours UART_BUS_RX_FIFO_EN to pick RX capacity.
module tb_uart_bus_responder;

    localparam int DIV      = 10;
    localparam int SYNC_LEN = 2;
`ifdef UART_BUS_RX_FIFO_EN
    localparam int RX_CAP   = 4;
    localparam int OVR_5    = 1;
`else
    localparam int RX_CAP   = 1;
    localparam int OVR_5    = 4;
`endif

    logic       CLK, RST, rdn, wrn, rxd;
    logic [7:0] data_in, data_out;
    logic       data_oe, data_ready, tbre, tsre, txd, frame_err, overrun, wr_drop;

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int cnt_fe = 0, cnt_ov = 0, cnt_wd = 0;
    int exp_fe = 0, exp_ov = 0;
    int mon_frames = 0;
    int mon_start[$];
    logic [9:0] mon_bits;
    logic [7:0] exp_q[$];       // bytes the host wrote that must appear on txd
    logic [7:0] rx_model[$];    // bytes the device must be holding for the host
    bit dr_chk = 0;
    bit mon_en = 0;

    uart_bus_responder #(.DIV(DIV), .SYNC_LEN(SYNC_LEN)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rdn       (rdn),
        .wrn       (wrn),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .data_ready(data_ready),
        .tbre      (tbre),
        .tsre      (tsre),
        .rxd       (rxd),
        .txd       (txd),
        .frame_err (frame_err),
        .overrun   (overrun),
        .wr_drop   (wr_drop)
    );

    // Clock and cycle counter.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse counters (high cycles, so a stretched pulse shows as an extra count).
    always @(negedge CLK) begin
        if (frame_err) cnt_fe++;
        if (overrun)   cnt_ov++;
        if (wr_drop)   cnt_wd++;
    end

    // Compare process: whenever the bus is quiet, data_ready follows the RX model.
    always @(negedge CLK) begin
        if (dr_chk) begin
            chk("data_ready_vs_model", data_ready, rx_model.size() != 0);
            chk("data_oe_idle", data_oe, 1'b0);
        end
    end

    // TX line monitor: decodes 8N1 frames on txd and checks them against exp_q.
    initial begin : tx_monitor
        logic [9:0] bits;
        logic [7:0] eb;
        forever begin
            @(negedge CLK);
            if (mon_en && !RST && txd == 1'b0) begin
                mon_start.push_back(cyc);
                repeat (DIV / 2) @(negedge CLK);
                bits[0] = txd;
                for (int i = 1; i < 10; i++) begin
                    repeat (DIV) @(negedge CLK);
                    bits[i] = txd;
                end
                mon_bits = bits;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected_frame: got bits %b, no byte pending", bits);
                end else begin
                    eb = exp_q.pop_front();
                    chk("tx_frame_bits", bits, {1'b1, eb, 1'b0});
                end
                mon_frames++;
            end
        end
    end

    task automatic host_write(input logic [7:0] b);
        data_in = b;
        wrn = 1'b0;
        repeat (2) @(negedge CLK);
        wrn = 1'b1;
        repeat (SYNC_LEN + 3) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        dr_chk = 0;
        rxd = 1'b0;
        repeat (DIV) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge CLK);
        end
        rxd = stop_bit;
        repeat (DIV) @(negedge CLK);
        rxd = 1'b1;
        repeat (2 * DIV) @(negedge CLK);
        if (!stop_bit) exp_fe++;
        else if (rx_model.size() < RX_CAP) rx_model.push_back(b);
        else exp_ov++;
        dr_chk = 1;
    endtask

    task automatic host_read(input logic [7:0] lit);
        logic [7:0] m;
        dr_chk = 0;
        m = (rx_model.size() != 0) ? rx_model[0] : 8'h00;
        rdn = 1'b0;
        repeat (SYNC_LEN + 3) @(negedge CLK);
        chk("read_oe", data_oe, 1'b1);
        chk("read_data_model", data_out, m);
        chk("read_data_literal", data_out, lit);
        rdn = 1'b1;
        repeat (SYNC_LEN + 3) @(negedge CLK);
        chk("read_oe_release", data_oe, 1'b0);
        if (rx_model.size() != 0) void'(rx_model.pop_front());
        dr_chk = 1;
    endtask

    task automatic wait_frames(input int n);
        int budget;
        budget = 0;
        while (mon_frames < n && budget < 40 * DIV) begin
            @(negedge CLK);
            budget++;
        end
        chk("tx_frame_count", mon_frames, n);
    endtask

    // Watchdog.
    initial begin
        #(20000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; rdn = 1'b1; wrn = 1'b1; rxd = 1'b1; data_in = 8'h00;
        repeat (3) @(negedge CLK);
        chk("rst_txd", txd, 1'b1);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_oe", data_oe, 1'b0);
        chk("rst_data_ready", data_ready, 1'b0);
        chk("rst_tbre", tbre, 1'b1);
        chk("rst_tsre", tsre, 1'b1);
        chk("rst_pulses", {frame_err, overrun, wr_drop}, 3'b000);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        dr_chk = 1;

        // Reset in the middle of a transmission with a byte stored.
        send_frame(8'h77, 1'b1);
        host_write(8'hA5);
        repeat (2 * DIV) @(negedge CLK);
        chk("pre_rst_tsre", tsre, 1'b0);
        chk("pre_rst_ready", data_ready, 1'b1);
        dr_chk = 0;
        #2 RST = 1'b1;
        #1;
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_tbre", tbre, 1'b1);
        chk("midrst_tsre", tsre, 1'b1);
        chk("midrst_ready", data_ready, 1'b0);
        chk("midrst_oe", data_oe, 1'b0);
        rx_model.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        dr_chk = 1;
        mon_en = 1;

        // Single write 0xA5.
        exp_q.push_back(8'hA5);
        host_write(8'hA5);
        chk("a5_tbre_after_shift", tbre, 1'b1);
        chk("a5_tsre_busy", tsre, 1'b0);
        wait_frames(1);
        chk("a5_bits_literal", mon_bits, 10'b1101001010);
        repeat (DIV) @(negedge CLK);
        chk("a5_tsre_done", tsre, 1'b1);

        // Back-to-back 0x55, 0x0F; third write while holding is full is dropped.
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0F);
        host_write(8'h55);
        host_write(8'h0F);
        chk("b2b_tbre_full", tbre, 1'b0);
        host_write(8'hAA);
        chk("wr_drop_count", cnt_wd, 1);
        wait_frames(3);
        if (mon_start.size() >= 3)
            chk("b2b_gap_cycles", mon_start[2] - mon_start[1], 10 * DIV);
        else
            chk("b2b_start_records", mon_start.size(), 3);
        repeat (12 * DIV) @(negedge CLK);
        chk("dropped_not_sent", mon_frames, 3);
        chk("tx_queue_drained", exp_q.size(), 0);
        chk("b2b_tsre_idle", tsre, 1'b1);

        // Receive 0x3C and read it back.
        send_frame(8'h3C, 1'b1);
        chk("rx3c_ready", data_ready, 1'b1);
        host_read(8'h3C);
        chk("rx3c_ready_after_read", data_ready, 1'b0);

        // Bad stop bit, then a short glitch.
        send_frame(8'hAA, 1'b0);
        chk("ferr_count_model", cnt_fe, exp_fe);
        chk("ferr_count_literal", cnt_fe, 1);
        chk("ferr_no_data", data_ready, 1'b0);
        rxd = 1'b0;
        repeat (DIV * 3 / 10) @(negedge CLK);
        rxd = 1'b1;
        repeat (2 * DIV) @(negedge CLK);
        chk("glitch_no_ferr", cnt_fe, 1);
        chk("glitch_no_data", data_ready, 1'b0);

        // Five frames with no reads: storage fills, the rest overrun.
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        chk("ovr_count_model", cnt_ov, exp_ov);
        chk("ovr_count_literal", cnt_ov, OVR_5);
        for (int b = 1; b <= RX_CAP; b++) host_read(8'(b));
        chk("drained_ready", data_ready, 1'b0);
        host_read(8'h00);
        chk("empty_read_no_change", data_ready, 1'b0);

        repeat (4) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
